inst_queue: RTL and testbench
=============================

INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter IQ_DEPTH, 16, number of entries; power of two, minimum 4.
REQ-002 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port rdy  input  1  global ready; low freezes all state.
REQ-005 SHALL have port misbranch_flag  input  1  flush request from ROB.
REQ-006 SHALL have port in_valid  input  1  one-cycle push pulse from fetcher.
REQ-007 SHALL have port in_inst  input  32  instruction word.
REQ-008 SHALL have port in_pc  input  32  instruction PC.
REQ-009 SHALL have port in_pred_jump  input  1  predicted-taken flag.
REQ-010 SHALL have port in_rollback_pc  input  32  fall-through PC (pc+4).
REQ-011 SHALL have port full_out  output  1  back-pressure to fetcher (feeds global full).
REQ-012 SHALL have port out_valid  output  1  head entry available.
REQ-013 SHALL have port out_ready  input  1  dispatcher accepts head this cycle.
REQ-014 SHALL have ports out_inst/out_pc/out_pred_jump/out_rollback_pc  output  32/32/1/32  head entry fields.

Function
REQ-015 SHALL store entries in a circular buffer with head/tail pointers of log2(IQ_DEPTH) bits, wrapping modulo IQ_DEPTH, plus a count of log2(IQ_DEPTH)+1 bits.
REQ-016 SHALL push when in_valid=1 and count<IQ_DEPTH, or count==IQ_DEPTH with a pop in the same cycle.
REQ-017 SHALL silently drop a push when count==IQ_DEPTH and no pop occurs (protocol violation; bench flags it).
REQ-018 SHALL pop when out_valid=1 and out_ready=1; head advances one entry.
REQ-019 SHALL drive out_valid=(count!=0) and out_* combinationally from storage[head]; out_* undefined-but-stable when out_valid=0.
REQ-020 SHALL leave count unchanged on simultaneous push and pop, including at count 0 (bypass off: no pop possible) and count IQ_DEPTH.
REQ-021 SHALL drive full_out=(count>=IQ_DEPTH-1), combinational from count only, covering the one in-flight fetcher push registered before full_out is seen.
REQ-022 SHALL, on misbranch_flag=1 with rdy=1, set head=tail=count=0 at that edge, ignore in_valid and out_ready in that cycle, and leave storage contents unchanged.
REQ-023 SHALL give misbranch_flag priority over push and pop; rst priority over everything.
REQ-024 SHALL, with rdy=0, hold pointers, count and storage; outputs still reflect held state.
REQ-025 SHALL have push-to-out_valid latency of one cycle (entry pushed at edge N visible after edge N) when IQ_BYPASS_EN undefined.
REQ-026 SHALL preserve FIFO order exactly across pointer wrap-around.

Reset
REQ-027 SHALL, while rst=1 at a posedge, set head=0, tail=0, count=0, regardless of rdy.
REQ-028 SHALL therefore present out_valid=0, full_out=0 after reset; storage need not be cleared.
REQ-029 SHALL abandon any in-progress push/pop when rst asserts mid-operation; no entry survives.

Configuration
REQ-030 SHALL recognise macro IQ_BYPASS_EN.
REQ-031 SHALL, with IQ_BYPASS_EN defined and count==0 and in_valid=1 and no flush, assert out_valid the same cycle with out_*=in_*; if out_ready=1 the entry is consumed without being written and count stays 0, else it is pushed normally.
REQ-032 SHALL, with IQ_BYPASS_EN undefined, never route in_* to out_*; REQ-025 latency applies.

Verification
REQ-033 SHALL cover: reset, push 3 entries pc 0x0,0x4,0x8 with out_ready=0 -> count 3, out_valid=1, out_pc=0x0, full_out=0.
REQ-034 SHALL cover: fill with IQ_DEPTH=16, out_ready=0 -> full_out rises when count reaches 15; 16th push accepted; count never exceeds 16.
REQ-035 SHALL cover: 40 pushes interleaved with random out_ready -> popped pc sequence equals pushed sequence 0x0..0x9C across two wraps.
REQ-036 SHALL cover: count 5, misbranch_flag=1 together with in_valid=1 and out_ready=1 -> next cycle count 0, out_valid=0, no pop observed.
REQ-037 SHALL cover: count 16 with simultaneous push and pop -> count stays 16, new entry appears at tail, old head dispatched.
REQ-038 SHALL cover: empty queue, in_valid=1, out_ready=1 -> bypass on: out_valid same cycle, count stays 0; bypass off: out_valid next cycle, count 1.

Source files
------------

// File: rtl/inst_queue.sv
// ---------------------------------------------------------------------------
// inst_queue
//
// Purpose:
//   Instruction queue between the fetcher and the dispatcher. Fetched
//   instructions are kept in a circular buffer. The head entry is always
//   presented on the out_* ports. A misbranch flush from the ROB empties the
//   queue in one cycle without touching the stored words.
//
// Optional feature (macro IQ_BYPASS_EN):
//   When defined, an instruction that arrives at an empty queue is shown on
//   out_* in the same cycle. If the dispatcher takes it in that cycle, it is
//   never written into storage. When undefined (the default build), a pushed
//   entry becomes visible one cycle after it is pushed.
//
// Parameters:
//   IQ_DEPTH        number of entries; power of two, at least 4
//
// Ports:
//   clk             clock; all state changes on the rising edge
//   rst             synchronous active-high reset; wins over everything
//   rdy             global ready; when low, all state is frozen
//   misbranch_flag  flush request from the ROB
//   in_valid        one-cycle push pulse from the fetcher
//   in_inst         instruction word
//   in_pc           instruction PC
//   in_pred_jump    predicted-taken flag
//   in_rollback_pc  fall-through PC (pc+4)
//   full_out        back-pressure to the fetcher
//   out_valid       head entry available
//   out_ready       dispatcher accepts the head this cycle
//   out_inst        head entry instruction word
//   out_pc          head entry PC
//   out_pred_jump   head entry predicted-taken flag
//   out_rollback_pc head entry fall-through PC
// ---------------------------------------------------------------------------
module inst_queue #(
    parameter int IQ_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        misbranch_flag,
    input  logic        in_valid,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    input  logic        in_pred_jump,
    input  logic [31:0] in_rollback_pc,
    output logic        full_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_pred_jump,
    output logic [31:0] out_rollback_pc
);

    localparam int PW = $clog2(IQ_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(IQ_DEPTH);
    localparam logic [CW-1:0] FULL_THR = CW'(IQ_DEPTH - 1);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        predJump;
        logic [31:0] rollbackPc;
    } entry_t;

    entry_t          storage_q [IQ_DEPTH];
    logic [PW-1:0]   head_q;
    logic [PW-1:0]   head_d;
    logic [PW-1:0]   tail_q;
    logic [PW-1:0]   tail_d;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;

    entry_t          inEntry;
    entry_t          outEntry;
    logic            notEmpty;
    logic            bypassHit;
    logic            popFire;
    logic            pushFire;
    logic            writeEn;
    logic            readEn;

    // Bundle the incoming fields so they can be stored or bypassed as one word.
    always_comb begin
        inEntry.inst       = in_inst;
        inEntry.pc         = in_pc;
        inEntry.predJump   = in_pred_jump;
        inEntry.rollbackPc = in_rollback_pc;
    end

    // Output selection and the push/pop handshake decisions.
    // A push into a full queue is accepted only if the head leaves in the
    // same cycle, so the slot being freed is the one being filled.
    // A bypassed entry that the dispatcher takes at once is not written to
    // storage, and it does not move the head.
    always_comb begin
        notEmpty  = (count_q != '0);
        bypassHit = 1'b0;
`ifdef IQ_BYPASS_EN
        bypassHit = !notEmpty && in_valid && !misbranch_flag;
`endif
        out_valid = notEmpty || bypassHit;
        outEntry  = bypassHit ? inEntry : storage_q[head_q];
        popFire   = out_valid && out_ready;
        pushFire  = in_valid && ((count_q < DEPTH_C) || popFire);
        writeEn   = pushFire && !(bypassHit && popFire);
        readEn    = popFire && !bypassHit;
    end

    always_comb begin
        out_inst        = outEntry.inst;
        out_pc          = outEntry.pc;
        out_pred_jump   = outEntry.predJump;
        out_rollback_pc = outEntry.rollbackPc;
        // The threshold is one below depth to cover the push that the fetcher
        // already has in flight before it sees full_out.
        full_out        = (count_q >= FULL_THR);
    end

    // Next pointer and count values. A flush empties the queue and ignores
    // that cycle's push and pop. Pointers wrap naturally because the depth is
    // a power of two.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (misbranch_flag) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (writeEn) begin
                tail_d = tail_q + PW'(1);
            end
            if (readEn) begin
                head_d = head_q + PW'(1);
            end
            case ({writeEn, readEn})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers. Reset wins even when rdy is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (rdy) begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is never cleared. A reset or a flush cancels the write
    // for that cycle, so only out_valid decides whether stale contents are seen.
    always_ff @(posedge clk) begin
        if (!rst && rdy && !misbranch_flag && writeEn) begin
            storage_q[tail_q] <= inEntry;
        end
    end

`ifndef SYNTHESIS
    // Occupancy must never exceed depth, and it must match the pointer distance.
    property pCountBound;
        @(posedge clk) disable iff (rst) (count_q <= DEPTH_C);
    endproperty
    aCountBound: assert property (pCountBound);

    property pPtrConsistent;
        @(posedge clk) disable iff (rst)
            ((count_q == DEPTH_C) ? (tail_q == head_q)
                                  : ((tail_q - head_q) == count_q[PW-1:0]));
    endproperty
    aPtrConsistent: assert property (pPtrConsistent);
`endif

endmodule

// File: tb/tb_inst_queue.sv
// ---------------------------------------------------------------------------
// tb_inst_queue
//
// Directed testbench for inst_queue with IQ_DEPTH = 16. Each scenario task
// drives its own stimulus and compares the outputs against values worked out
// by hand. Inputs change 1 time unit after a rising edge, and outputs are
// sampled before the next edge.
// ---------------------------------------------------------------------------
module tb_inst_queue;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        misbranch_flag;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        in_pred_jump;
    logic [31:0] in_rollback_pc;
    logic        full_out;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_pred_jump;
    logic [31:0] out_rollback_pc;

    int          errCount;
    int          checkCount;
    int          drainCnt;
    logic [31:0] drainPcs [0:31];

    inst_queue #(.IQ_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .misbranch_flag  (misbranch_flag),
        .in_valid        (in_valid),
        .in_inst         (in_inst),
        .in_pc           (in_pc),
        .in_pred_jump    (in_pred_jump),
        .in_rollback_pc  (in_rollback_pc),
        .full_out        (full_out),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_inst        (out_inst),
        .out_pc          (out_pc),
        .out_pred_jump   (out_pred_jump),
        .out_rollback_pc (out_rollback_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sets the fetch fields from the PC, with the other fields derived from it.
    task automatic setIn(input logic [31:0] pc);
        in_pc          = pc;
        in_inst        = pc ^ 32'hA5A5_0000;
        in_pred_jump   = pc[2];
        in_rollback_pc = pc + 32'd4;
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Pushes one entry while the dispatcher is idle.
    task automatic pushOne(input logic [31:0] pc);
        setIn(pc);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Pops everything, recording the PCs. The loop is bounded so the bench cannot hang.
    task automatic drainQueue();
        drainCnt       = 0;
        in_valid       = 1'b0;
        misbranch_flag = 1'b0;
        out_ready      = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!out_valid) break;
            if (drainCnt < 32) drainPcs[drainCnt] = out_pc;
            drainCnt++;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        pushOne(32'h40);
        pushOne(32'h44);
        // Reset must win even with rdy low and a push/pop pending.
        rst = 1'b1; rdy = 1'b0; in_valid = 1'b1; out_ready = 1'b1; setIn(32'h48);
        @(posedge clk); #1;
        rst = 1'b0; rdy = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        checkCount++;
        if (out_valid !== 1'b0) begin
            errCount++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid);
        end
        checkCount++;
        if (full_out !== 1'b0) begin
            errCount++; $display("[TB] FAIL reset_full: got %b expected 0", full_out);
        end
    endtask

    task automatic test_push_three();
        doReset();
        pushOne(32'h0);
        pushOne(32'h4);
        pushOne(32'h8);
        #1;
        checkCount++;
        if (out_valid !== 1'b1) begin
            errCount++; $display("[TB] FAIL push3_valid: got %b expected 1", out_valid);
        end
        checkCount++;
        if (out_pc !== 32'h0) begin
            errCount++; $display("[TB] FAIL push3_pc: got %h expected 00000000", out_pc);
        end
        checkCount++;
        if (out_inst !== 32'hA5A5_0000 || out_rollback_pc !== 32'h4 || out_pred_jump !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL push3_fields: got inst=%h rb=%h pj=%b expected a5a50000 00000004 0",
                     out_inst, out_rollback_pc, out_pred_jump);
        end
        checkCount++;
        if (full_out !== 1'b0) begin
            errCount++; $display("[TB] FAIL push3_full: got %b expected 0", full_out);
        end
        drainQueue();
        checkCount++;
        if (drainCnt !== 3 || drainPcs[1] !== 32'h4 || drainPcs[2] !== 32'h8) begin
            errCount++;
            $display("[TB] FAIL push3_drain: got cnt=%0d pc1=%h pc2=%h expected 3 00000004 00000008",
                     drainCnt, drainPcs[1], drainPcs[2]);
        end
    endtask

    task automatic test_fill();
        doReset();
        for (int k = 1; k <= DEPTH; k++) begin
            pushOne(32'(k - 1) * 32'd4);
            #1;
            checkCount++;
            if (full_out !== (k >= DEPTH - 1)) begin
                errCount++;
                $display("[TB] FAIL fill_full k=%0d: got %b expected %b", k, full_out, (k >= DEPTH - 1));
            end
        end
        // Push into a full queue with no pop: this must be dropped.
        pushOne(32'h100);
        #1;
        checkCount++;
        if (full_out !== 1'b1 || out_pc !== 32'h0) begin
            errCount++;
            $display("[TB] FAIL fill_overflow: got full=%b pc=%h expected 1 00000000", full_out, out_pc);
        end
        drainQueue();
        checkCount++;
        if (drainCnt !== DEPTH || drainPcs[15] !== 32'h3C) begin
            errCount++;
            $display("[TB] FAIL fill_drain: got cnt=%0d last=%h expected 16 0000003c", drainCnt, drainPcs[15]);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] expQ[$];
        int          pushed;
        int          popped;
        int          mcount;
        bit          doPush;
        bit          doPop;
        bit          rd;
        bit          expValid;
        pushed = 0; popped = 0; mcount = 0;
        doReset();
        for (int cyc = 0; cyc < 600 && popped < 40; cyc++) begin
            rd        = (pushed >= 40) ? 1'b1 : 1'($urandom_range(0, 1));
            out_ready = rd;
            doPush    = (pushed < 40) && ((mcount < DEPTH) || (mcount != 0 && rd));
            in_valid  = doPush;
            setIn(32'(pushed) * 32'd4);
            #1;
            expValid = (mcount != 0);
`ifdef IQ_BYPASS_EN
            expValid = expValid || doPush;
`endif
            checkCount++;
            if (out_valid !== expValid) begin
                errCount++;
                $display("[TB] FAIL wrap_valid cyc=%0d: got %b expected %b", cyc, out_valid, expValid);
            end
            doPop = expValid && rd;
            if (doPush) expQ.push_back(32'(pushed) * 32'd4);
            if (doPop) begin
                checkCount++;
                if (expQ.size() == 0 || out_pc !== expQ[0]) begin
                    errCount++;
                    $display("[TB] FAIL wrap_order pop=%0d: got %h expected %h",
                             popped, out_pc, (expQ.size() == 0) ? 32'hX : expQ[0]);
                end
                if (expQ.size() != 0) void'(expQ.pop_front());
                popped++;
            end
            if (doPush) pushed++;
            mcount = mcount + int'(doPush) - int'(doPop);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkCount++;
        if (popped !== 40) begin
            errCount++; $display("[TB] FAIL wrap_total: got %0d expected 40", popped);
        end
    endtask

    task automatic test_flush();
        doReset();
        for (int k = 0; k < 5; k++) pushOne(32'h20 + 32'(k) * 32'd4);
        misbranch_flag = 1'b1; in_valid = 1'b1; out_ready = 1'b1; setIn(32'h200);
        @(posedge clk); #1;
        misbranch_flag = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        checkCount++;
        if (out_valid !== 1'b0 || full_out !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL flush_empty: got valid=%b full=%b expected 0 0", out_valid, full_out);
        end
        pushOne(32'h300);
        #1;
        checkCount++;
        if (out_valid !== 1'b1 || out_pc !== 32'h300) begin
            errCount++;
            $display("[TB] FAIL flush_repush: got valid=%b pc=%h expected 1 00000300", out_valid, out_pc);
        end
        drainQueue();
        checkCount++;
        if (drainCnt !== 1) begin
            errCount++; $display("[TB] FAIL flush_drain: got %0d expected 1", drainCnt);
        end
    endtask

    task automatic test_rdy_hold();
        doReset();
        pushOne(32'h10);
        pushOne(32'h14);
        rdy = 1'b0; in_valid = 1'b1; out_ready = 1'b1; misbranch_flag = 1'b1; setIn(32'h18);
        repeat (3) @(posedge clk);
        #1;
        rdy = 1'b1; in_valid = 1'b0; out_ready = 1'b0; misbranch_flag = 1'b0;
        #1;
        checkCount++;
        if (out_valid !== 1'b1 || out_pc !== 32'h10) begin
            errCount++;
            $display("[TB] FAIL hold_head: got valid=%b pc=%h expected 1 00000010", out_valid, out_pc);
        end
        drainQueue();
        checkCount++;
        if (drainCnt !== 2 || drainPcs[1] !== 32'h14) begin
            errCount++;
            $display("[TB] FAIL hold_drain: got cnt=%0d pc1=%h expected 2 00000014", drainCnt, drainPcs[1]);
        end
    endtask

    task automatic test_mid_reset();
        doReset();
        for (int k = 0; k < 3; k++) pushOne(32'h60 + 32'(k) * 32'd4);
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; setIn(32'h70);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        checkCount++;
        if (out_valid !== 1'b0) begin
            errCount++; $display("[TB] FAIL midrst_valid: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_full_simul();
        doReset();
        for (int k = 0; k < DEPTH; k++) pushOne(32'(k) * 32'd4);
        setIn(32'h400); in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checkCount++;
        if (out_pc !== 32'h0) begin
            errCount++; $display("[TB] FAIL simul_head: got %h expected 00000000", out_pc);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        checkCount++;
        if (full_out !== 1'b1) begin
            errCount++; $display("[TB] FAIL simul_full: got %b expected 1", full_out);
        end
        drainQueue();
        checkCount++;
        if (drainCnt !== DEPTH || drainPcs[0] !== 32'h4 || drainPcs[14] !== 32'h3C || drainPcs[15] !== 32'h400) begin
            errCount++;
            $display("[TB] FAIL simul_drain: got cnt=%0d first=%h p14=%h last=%h expected 16 00000004 0000003c 00000400",
                     drainCnt, drainPcs[0], drainPcs[14], drainPcs[15]);
        end
    endtask

    task automatic test_bypass();
        doReset();
        setIn(32'h500); in_valid = 1'b1; out_ready = 1'b1;
        #1;
`ifdef IQ_BYPASS_EN
        checkCount++;
        if (out_valid !== 1'b1 || out_pc !== 32'h500) begin
            errCount++;
            $display("[TB] FAIL bypass_same: got valid=%b pc=%h expected 1 00000500", out_valid, out_pc);
        end
`else
        checkCount++;
        if (out_valid !== 1'b0) begin
            errCount++; $display("[TB] FAIL bypass_same: got valid=%b expected 0", out_valid);
        end
`endif
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
`ifdef IQ_BYPASS_EN
        checkCount++;
        if (out_valid !== 1'b0) begin
            errCount++; $display("[TB] FAIL bypass_next: got valid=%b expected 0", out_valid);
        end
`else
        checkCount++;
        if (out_valid !== 1'b1 || out_pc !== 32'h500) begin
            errCount++;
            $display("[TB] FAIL bypass_next: got valid=%b pc=%h expected 1 00000500", out_valid, out_pc);
        end
        drainQueue();
        checkCount++;
        if (drainCnt !== 1) begin
            errCount++; $display("[TB] FAIL bypass_count: got %0d expected 1", drainCnt);
        end
`endif
    endtask

    initial begin
        errCount       = 0;
        checkCount     = 0;
        rst            = 1'b1;
        rdy            = 1'b1;
        misbranch_flag = 1'b0;
        in_valid       = 1'b0;
        out_ready      = 1'b0;
        setIn(32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        test_reset();
        test_push_three();
        test_fill();
        test_wrap();
        test_flush();
        test_rdy_hold();
        test_mid_reset();
        test_full_simul();
        test_bypass();
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
